// File: rtl/agen_pipe.sv
// agen_pipe: pipelined address-generation unit for the load/store issue lane.
// Computes data1 + sign-extended immediate, decodes access size and flags, and
// forwards tags and store data toward the LSQ. Every stage applies branch-mask
// squash and verify-correct mask clearing each cycle.
//
// Handshake: a packet moves across an interface on a clock edge where valid
// and ready are both 1. in_ready_o never depends on in_valid_i. out_valid_o
// may drop while out_ready_i is low, but only because of a squash.
//
// Optional feature macro: AGEN_MISALIGN_TRAP_EN
//   defined   -> out_flags_o[0] reports misalignment, out_addr_o is the raw sum
//   undefined -> out_flags_o[0] = 0, out_addr_o low bits forced to alignment
module agen_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int OPC_W    = 8,
  parameter int CKPT     = 4,
  parameter int CKPT_LOG = 2,
  parameter int META_W   = 24,
  parameter int STAGES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CKPT-1:0]     in_mask_i,
  input  logic [META_W-1:0]   in_meta_i,
  input  logic [OPC_W-1:0]    in_opcode_i,
  input  logic [IMM_W-1:0]    in_imm_i,
  input  logic [DATA_W-1:0]   in_data1_i,
  input  logic [DATA_W-1:0]   in_data2_i,
  input  logic                ctrlVerified_i,
  input  logic                ctrlMispredict_i,
  input  logic [CKPT_LOG-1:0] ctrlSMTid_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CKPT-1:0]     out_mask_o,
  output logic [META_W-1:0]   out_meta_o,
  output logic [DATA_W-1:0]   out_addr_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [1:0]          out_size_o,
  output logic [2:0]          out_flags_o
);

  localparam int LAST = STAGES - 1;

  // Per-stage state; only the valid bits are reset, payload is don't-care.
  logic [STAGES-1:0] valid_q;
  logic [CKPT-1:0]   mask_q [STAGES];
  logic [META_W-1:0] meta_q [STAGES];
  logic [3:0]        opc_q  [STAGES];
  logic [DATA_W-1:0] addr_q [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];

  // What each stage would capture if it loads this cycle.
  logic [STAGES-1:0] valid_d;
  logic [CKPT-1:0]   mask_d [STAGES];
  logic [META_W-1:0] meta_d [STAGES];
  logic [3:0]        opc_d  [STAGES];
  logic [DATA_W-1:0] addr_d [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];

  logic              squash;
  logic [CKPT-1:0]   clr_mask;
  logic              in_kill;
  logic [DATA_W-1:0] sum;
  logic [STAGES-1:0] live;
  logic [STAGES-1:0] load;
  logic              room;
  logic              unused_opc;

  // Only size/unsigned/store bits of the opcode matter to this unit.
  assign unused_opc = ^in_opcode_i[OPC_W-1:4];

  assign squash   = ctrlVerified_i & ctrlMispredict_i;
  assign clr_mask = (ctrlVerified_i & ~ctrlMispredict_i) ? (CKPT'(1) << ctrlSMTid_i) : '0;
  assign in_kill  = squash & in_mask_i[ctrlSMTid_i];
  assign sum      = in_data1_i + {{(DATA_W-IMM_W){in_imm_i[IMM_W-1]}}, in_imm_i};

  // Squashed stages count as empty, so a stage may load whenever it or any
  // stage downstream of it is empty, or the output is being accepted.
  always_comb begin
    room = out_ready_i;
    live = '0;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      live[k] = valid_q[k] & ~(squash & mask_q[k][ctrlSMTid_i]);
      room    = room | ~live[k];
      load[k] = room;
    end
  end

  // Source of each stage: the issue port for stage 0, the upstream stage otherwise.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid_i & ~in_kill;
    mask_d[0]  = in_mask_i & ~clr_mask;
    meta_d[0]  = in_meta_i;
    opc_d[0]   = in_opcode_i[3:0];
    addr_d[0]  = sum;
    data_d[0]  = in_data2_i;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = live[k-1];
      mask_d[k]  = mask_q[k-1] & ~clr_mask;
      meta_d[k]  = meta_q[k-1];
      opc_d[k]   = opc_q[k-1];
      addr_d[k]  = addr_q[k-1];
      data_d[k]  = data_q[k-1];
    end
  end

  // Stage valid bits: load from upstream, otherwise hold (minus any squash).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= load[k] ? valid_d[k] : live[k];
      end
    end
  end

  // Stage payload: load from upstream, otherwise hold with verify clearing applied.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        mask_q[k] <= mask_d[k];
        meta_q[k] <= meta_d[k];
        opc_q[k]  <= opc_d[k];
        addr_q[k] <= addr_d[k];
        data_q[k] <= data_d[k];
      end else begin
        mask_q[k] <= mask_q[k] & ~clr_mask;
      end
    end
  end

  logic [1:0] size_raw;
  logic       is_h;
  logic       is_w;

  assign size_raw = opc_q[LAST][1:0];
  assign is_h     = (size_raw == 2'b01);
  assign is_w     = size_raw[1];

  assign in_ready_o  = load[0];
  assign out_valid_o = live[LAST];
  assign out_mask_o  = mask_q[LAST] & ~clr_mask;
  assign out_meta_o  = meta_q[LAST];
  assign out_data_o  = data_q[LAST];
  // Reserved size 11 behaves as a word access.
  assign out_size_o  = is_w ? 2'b10 : size_raw;

`ifdef AGEN_MISALIGN_TRAP_EN
  logic misaligned;

  // Flag misalignment and pass the raw sum through.
  always_comb begin
    misaligned  = (is_h & addr_q[LAST][0]) | (is_w & (addr_q[LAST][1:0] != 2'b00));
    out_addr_o  = addr_q[LAST];
    out_flags_o = {opc_q[LAST][2], opc_q[LAST][3], misaligned};
  end
`else
  // No trap: silently align the address to the access size.
  always_comb begin
    out_addr_o = addr_q[LAST];
    if (is_w) begin
      out_addr_o[1:0] = 2'b00;
    end else if (is_h) begin
      out_addr_o[0] = 1'b0;
    end
    out_flags_o = {opc_q[LAST][2], opc_q[LAST][3], 1'b0};
  end
`endif

endmodule
